// File: rtl/pht_update_ctrl_pkg.sv
// pht_update_ctrl_pkg: shared widths and in-flight entry type (GSHARE_EN adds the history snapshot field)
package pht_update_ctrl_pkg;
  localparam int IDX_W_DEF = 8;
  localparam int GHR_W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic                 pred;
`ifdef GSHARE_EN
    logic [GHR_W_DEF-1:0] ghr_snap;
`endif
  } entry_t;
endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: circular queue of in-flight branch entries with push/pop/flush
module bp_inflight_fifo
  import pht_update_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t din,
  output entry_t head_entry,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0] count;
  assign head_entry = mem[head];
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  // entry storage; validity is tracked by count so no reset is needed
  always_ff @(posedge clk)
    if (push) mem[tail] <= din;
  // pointer and occupancy bookkeeping; a flush discards everything still queued
  always_ff @(posedge clk)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
endmodule

// File: rtl/pht_update_ctrl.sv
// pht_update_ctrl: PHT port initiator tracking in-flight predictions (GSHARE_EN enables global-history indexing)
module pht_update_ctrl
  import pht_update_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int GHR_W = GHR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [IDX_W-1:0] br_pc,
  output logic             br_ready,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             res_taken,
  output logic             mispredict,
  output logic             res_error,
  output logic [IDX_W-1:0] pht_addr,
  output logic             pht_request,
  output logic             pht_result,
  output logic             pht_taken,
  input  logic             pht_prediction
);
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] idx;
  logic full, empty, accept, resolve;
  entry_t head_e, push_e;
  assign br_ready = !rst && !full && !res_valid;
  assign accept = br_valid && br_ready;
  assign resolve = !rst && res_valid && !empty;
  assign res_error = !rst && res_valid && empty;
  assign mispredict = resolve && (res_taken != head_e.pred);
  assign pred_taken = accept && pht_prediction;
  assign pht_request = accept;
  assign pht_result = resolve;
  assign pht_taken = resolve && res_taken;
  assign pht_addr = resolve ? head_e.idx : accept ? idx : '0;
  assign idx = br_pc ^ ghr;
`ifdef GSHARE_EN
  assign push_e = '{idx: idx, pred: pred_taken, ghr_snap: ghr};
  // speculative history shifts in each prediction and is repaired from the head snapshot on mispredict
  always_ff @(posedge clk)
    if (rst) ghr <= '0;
    else if (mispredict) ghr <= {head_e.ghr_snap[GHR_W-2:0], res_taken};
    else if (accept) ghr <= {ghr[GHR_W-2:0], pred_taken};
`else
  assign push_e = '{idx: idx, pred: pred_taken};
  assign ghr = '0;
`endif
  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(accept),
    .pop(resolve),
    .flush(mispredict),
    .din(push_e),
    .head_entry(head_e),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_pht_update_ctrl.sv
// tb_pht_update_ctrl: randomized check of pht_update_ctrl against a queue-based reference model
module tb_pht_update_ctrl;
  localparam int DEPTH = 4;
`ifdef GSHARE_EN
  localparam bit GS = 1'b1;
`else
  localparam bit GS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, br_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0, pht_prediction = 1'b0;
  logic [7:0] br_pc = '0;
  logic br_ready, pred_taken, mispredict, res_error, pht_request, pht_result, pht_taken;
  logic [7:0] pht_addr;
  int n_chk = 0, n_fail = 0;
  typedef struct {int idx; bit pred; int snap;} ment_t;
  ment_t q[$];
  int ghr = 0;
  always #5 clk = ~clk;
  pht_update_ctrl #(.DEPTH(DEPTH), .IDX_W(8), .GHR_W(8)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_pc(br_pc), .br_ready(br_ready),
    .pred_taken(pred_taken), .res_valid(res_valid), .res_taken(res_taken),
    .mispredict(mispredict), .res_error(res_error), .pht_addr(pht_addr),
    .pht_request(pht_request), .pht_result(pht_result), .pht_taken(pht_taken),
    .pht_prediction(pht_prediction)
  );
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cycle(bit r, bit bv, logic [7:0] pc, bit pp, bit rv, bit rt);
    bit acc, resv, err, mis, rdy;
    int e_idx, e_addr;
    ment_t h;
    @(negedge clk);
    rst = r; br_valid = bv; br_pc = pc; pht_prediction = pp; res_valid = rv; res_taken = rt;
    #1;
    rdy = !r && q.size() < DEPTH && !rv;
    acc = bv && rdy;
    resv = !r && rv && q.size() > 0;
    err = !r && rv && q.size() == 0;
    h = '{0, 1'b0, 0};
    if (resv) h = q[0];
    mis = resv && (h.pred != rt);
    e_idx = (int'(pc) ^ (GS ? ghr : 0)) & 255;
    e_addr = resv ? h.idx : acc ? e_idx : 0;
    chk("br_ready", br_ready, rdy);
    chk("pht_request", pht_request, acc);
    chk("pht_result", pht_result, resv);
    chk("pht_addr", pht_addr, e_addr);
    chk("res_error", res_error, err);
    chk("mispredict", mispredict, mis);
    if (acc) chk("pred_taken", pred_taken, pp);
    if (resv) chk("pht_taken", pht_taken, rt);
    if (r) begin
      q.delete();
      ghr = 0;
    end else begin
      if (acc) begin
        q.push_back('{e_idx, pp, ghr});
        if (GS) ghr = ((ghr << 1) | int'(pp)) & 255;
      end
      if (resv) begin
        void'(q.pop_front());
        if (mis) begin
          q.delete();
          if (GS) ghr = ((h.snap << 1) | int'(rt)) & 255;
        end
      end
    end
  endtask
  initial begin
    cycle(1, 0, 8'h00, 0, 0, 0);
    cycle(1, 1, 8'h11, 1, 1, 1);
    chk("rst_ready", br_ready, 0);
    chk("rst_request", pht_request, 0);
    cycle(0, 1, 8'h3C, 1, 0, 0);
    chk("d1_addr", pht_addr, 8'h3C);
    chk("d1_pred", pred_taken, 1);
    cycle(0, 1, 8'h3C, 0, 0, 0);
    chk("d2_addr", pht_addr, GS ? 8'h3D : 8'h3C);
    cycle(0, 1, 8'h10, 1, 0, 0);
    cycle(0, 1, 8'h20, 1, 0, 0);
    cycle(0, 1, 8'h55, 1, 1, 1);
    chk("full_ready", br_ready, 0);
    chk("full_result", pht_result, 1);
    chk("full_request", pht_request, 0);
    chk("full_addr", pht_addr, 8'h3C);
    chk("full_mis", mispredict, 0);
    cycle(0, 0, 8'h00, 0, 1, 1);
    chk("mis_pulse", mispredict, 1);
    chk("mis_addr", pht_addr, GS ? 8'h3D : 8'h3C);
    cycle(0, 0, 8'h00, 0, 1, 0);
    chk("flush_err", res_error, 1);
    chk("flush_result", pht_result, 0);
    cycle(0, 1, 8'h00, 0, 0, 0);
    chk("repair_addr", pht_addr, GS ? 8'h03 : 8'h00);
    cycle(0, 1, 8'h40, 1, 0, 0);
    cycle(1, 1, 8'h40, 1, 1, 0);
    chk("mid_rst_ready", br_ready, 0);
    chk("mid_rst_result", pht_result, 0);
    cycle(0, 0, 8'h00, 0, 1, 1);
    chk("post_rst_err", res_error, 1);
    cycle(0, 1, 8'h3C, 0, 0, 0);
    chk("post_rst_addr", pht_addr, 8'h3C);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
            1'($urandom), $urandom_range(0, 9) < 3, 1'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
